// File: rtl/atctlc2axi500_sink_id_pkg.sv
// Shared definitions for the sink-ID pool: per-entry state encoding and count width.
package atctlc2axi500_sink_id_pkg;

   localparam logic [1:0] ST_FREE = 2'd0;
   localparam logic [1:0] ST_PEND = 2'd1;
   localparam logic [1:0] ST_RSPD = 2'd2;
   localparam logic [1:0] ST_ACKD = 2'd3;

   // One extra bit so a full pool (2**SINK_WIDTH entries) can be counted.
   function automatic int cnt_width(input int sink_width);
      return sink_width + 1;
   endfunction

endpackage

// File: rtl/atctlc2axi500_sink_id_fsm.sv
// Lifecycle of one sink ID: allocation, response, acknowledge and return to the pool.
//
// state | meaning
// FREE  | ID available for allocation
// PEND  | allocated, waiting for rsp and ack
// RSPD  | rsp seen, waiting for ack
// ACKD  | ack seen first (RAR mode only), waiting for rsp
module atctlc2axi500_sink_id_fsm
   import atctlc2axi500_sink_id_pkg::*;
#(
   parameter int RAR_SUPPORT = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enq,
   input  logic       rsp,
   input  logic       ack,
   output logic [1:0] state,
   output logic       free_pulse,
   output logic       err
);

   logic [1:0] state_nxt;

   // An illegal event only raises err; a legal event in the same cycle still applies.
   always_comb begin
      state_nxt  = state;
      free_pulse = 1'b0;
      err        = 1'b0;
      case (state)
         ST_FREE: begin
            if (enq) state_nxt = ST_PEND;
            if (rsp || ack) err = 1'b1;
         end
         ST_PEND: begin
            if (rsp && ack) begin
               state_nxt  = ST_FREE;
               free_pulse = 1'b1;
            end else if (rsp) begin
               state_nxt = ST_RSPD;
            end else if (ack) begin
               if (RAR_SUPPORT != 0) state_nxt = ST_ACKD;
               else                  err = 1'b1;
            end
         end
         ST_RSPD: begin
            if (rsp) err = 1'b1;
            if (ack) begin
               state_nxt  = ST_FREE;
               free_pulse = 1'b1;
            end
         end
         default: begin
            if (ack) err = 1'b1;
            if (rsp) begin
               state_nxt  = ST_FREE;
               free_pulse = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= ST_FREE;
      else       state <= state_nxt;
   end

endmodule

// File: rtl/atctlc2axi500_sink_id_pool_rr.sv
// Round-robin sink-ID allocator with high-priority reserve, free counter and error flag.
module atctlc2axi500_sink_id_pool_rr
   import atctlc2axi500_sink_id_pkg::*;
#(
   parameter int SINK_WIDTH  = 3,
   parameter int ENT_NUM     = 2**SINK_WIDTH,
   parameter int RAR_SUPPORT = 0,
   parameter int RESERVE_NUM = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   input  logic                  req_hipri,
   output logic                  req_ready,
   output logic [SINK_WIDTH-1:0] req_sink,
   input  logic                  rsp_valid,
   input  logic [SINK_WIDTH-1:0] rsp_sink,
   input  logic                  ack_valid,
   input  logic [SINK_WIDTH-1:0] ack_sink,
   output logic                  busy,
   output logic [SINK_WIDTH:0]   free_cnt,
   output logic                  err_valid
);

   localparam int CW = cnt_width(SINK_WIDTH);

   logic [ENT_NUM-1:0]    enq_vec;
   logic [ENT_NUM-1:0]    rsp_vec;
   logic [ENT_NUM-1:0]    ack_vec;
   logic [ENT_NUM-1:0]    free_vec;
   logic [ENT_NUM-1:0]    free_pulse;
   logic [ENT_NUM-1:0]    err_vec;
   logic [ENT_NUM-1:0]    rot_free;
   logic [1:0]            ent_state [ENT_NUM];
   logic [SINK_WIDTH-1:0] last_ptr;
   logic [CW-1:0]         frees;
   logic                  grant;
   logic                  rsp_oor;
   logic                  ack_oor;

   for (genvar i = 0; i < ENT_NUM; i++) begin : g_ent
      atctlc2axi500_sink_id_fsm #(
         .RAR_SUPPORT(RAR_SUPPORT)
      ) u_fsm (
         .clk       (clk),
         .reset     (reset),
         .enq       (enq_vec[i]),
         .rsp       (rsp_vec[i]),
         .ack       (ack_vec[i]),
         .state     (ent_state[i]),
         .free_pulse(free_pulse[i]),
         .err       (err_vec[i])
      );
      assign free_vec[i] = (ent_state[i] == ST_FREE);
   end

   // Rotate the free vector so bit 0 is the slot after last_ptr, then take the first one.
   always_comb begin
      int idx;
      int pos;
      rot_free = '0;
      pos      = 0;
      for (int k = 0; k < ENT_NUM; k++) begin
         idx = int'(last_ptr) + 1 + k;
         if (idx >= ENT_NUM) idx = idx - ENT_NUM;
         rot_free[k] = free_vec[idx];
      end
      for (int k = ENT_NUM - 1; k >= 0; k--) begin
         if (rot_free[k]) pos = k;
      end
      idx = int'(last_ptr) + 1 + pos;
      if (idx >= ENT_NUM) idx = idx - ENT_NUM;
      req_sink = SINK_WIDTH'(idx);
   end

   assign req_ready = (free_cnt > CW'(RESERVE_NUM)) | (req_hipri & (free_cnt != '0));
   assign grant     = req_valid & req_ready;
   assign busy      = (free_cnt == '0);
   assign rsp_oor   = rsp_valid && (int'(rsp_sink) >= ENT_NUM);
   assign ack_oor   = ack_valid && (int'(ack_sink) >= ENT_NUM);

   always_comb begin
      enq_vec = '0;
      rsp_vec = '0;
      ack_vec = '0;
      for (int i = 0; i < ENT_NUM; i++) begin
         enq_vec[i] = grant     && (int'(req_sink) == i);
         rsp_vec[i] = rsp_valid && (int'(rsp_sink) == i);
         ack_vec[i] = ack_valid && (int'(ack_sink) == i);
      end
   end

   always_comb begin
      frees = '0;
      for (int i = 0; i < ENT_NUM; i++) begin
         frees = frees + CW'(free_pulse[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         free_cnt  <= CW'(ENT_NUM);
         last_ptr  <= SINK_WIDTH'(ENT_NUM - 1);
         err_valid <= 1'b0;
      end else begin
         free_cnt  <= free_cnt + frees - CW'(grant);
         if (grant) last_ptr <= req_sink;
         err_valid <= (|err_vec) | rsp_oor | ack_oor;
      end
   end

endmodule
